// File: rtl/gs_audio_pkg.sv
// Shared widths, sample type and saturation helper for the gs_audio_out slice.
package gs_audio_pkg;

  localparam int unsigned IN_W     = 15;
  localparam int unsigned OUT_W    = 16;
  localparam int unsigned FRAC     = 8;
  localparam int unsigned DC_SHIFT = 8;
  localparam int unsigned Y_W      = 17;  // stage-1 result width
  localparam int unsigned G_W      = 20;  // gained value, y <<< 3 headroom
  localparam int unsigned ACC_W    = 25;  // x - dc headroom for the DC tracker

  typedef logic signed [OUT_W-1:0] sample_t;

  // Saturation result: clamped PCM plus a flag when clamping happened
  typedef struct packed {
    logic    clip;
    sample_t pcm;
  } sat_t;

  localparam logic signed [G_W-1:0] G_HI = {{(G_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [G_W-1:0] G_LO = {{(G_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  // Clamp a gained value to the signed OUT_W range
  function automatic sat_t saturate(input logic signed [G_W-1:0] g);
    sat_t r;
    r.clip = 1'b0;
    r.pcm  = sample_t'(g);
    if (g > G_HI) begin
      r.clip = 1'b1;
      r.pcm  = {1'b0, {(OUT_W-1){1'b1}}};
    end else if (g < G_LO) begin
      r.clip = 1'b1;
      r.pcm  = {1'b1, {(OUT_W-1){1'b0}}};
    end
    return r;
  endfunction

endpackage

// File: rtl/gs_sdm.sv
// One-channel first-order sigma-delta modulator driving an RC DAC pin.
module gs_sdm
  import gs_audio_pkg::*;
(
  input  logic    CLK,
  input  logic    RESET_n,
  input  sample_t PCM,
  output logic    DAC
);

  logic [OUT_W-1:0] acc_q;
  logic [OUT_W-1:0] u_c;
  logic [OUT_W:0]   sum_c;

  // Offset-binary input so ones density tracks (PCM + 32768) / 65536
  assign u_c   = PCM ^ {1'b1, {(OUT_W-1){1'b0}}};
  assign sum_c = {1'b0, acc_q} + {1'b0, u_c};

  // Accumulate every clock; the carry out is the bitstream
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      acc_q <= '0;
      DAC   <= 1'b0;
    end else begin
      acc_q <= sum_c[OUT_W-1:0];
      DAC   <= sum_c[OUT_W];
    end
  end

endmodule

// File: rtl/gs_audio_out.sv
// General Sound output stage: DC removal, gain, saturation, mute, PCM and
// sigma-delta DAC streams. Define GS_AUDIO_DCBLOCK_EN to build the DC blocker;
// without it stage 1 passes the input straight through.
module gs_audio_out
  import gs_audio_pkg::*;
(
  input  logic                 CLK,
  input  logic                 RESET_n,
  input  logic                 CE,
  input  logic [IN_W-1:0]      INL,
  input  logic [IN_W-1:0]      INR,
  input  logic [1:0]           GAIN,
  input  logic                 MUTE,
  input  logic                 CLIP_CLR,
  output logic [OUT_W-1:0]     PCM_L,
  output logic [OUT_W-1:0]     PCM_R,
  output logic                 PCM_VALID,
  output logic                 CLIP,
  output logic                 DAC_L,
  output logic                 DAC_R
);

  logic [1:0][IN_W-1:0]  in_c;
  logic [1:0][OUT_W-1:0] pcm_c;
  logic [1:0]            clip_c;
  logic                  s1_valid;

  assign in_c  = {INR, INL};
  assign PCM_L = pcm_c[0];
  assign PCM_R = pcm_c[1];

  for (genvar ch = 0; ch < 2; ch++) begin : g_ch
    logic signed [IN_W-1:0] in_s;
    logic signed [Y_W-1:0]  y_q;
    logic signed [G_W-1:0]  g_c;
    sat_t                   sat_c;
    sample_t                pcm_q;

    assign in_s = signed'(in_c[ch]);

`ifdef GS_AUDIO_DCBLOCK_EN
    logic signed [ACC_W-1:0] dc_q;
    logic signed [ACC_W-1:0] x_c;
    logic signed [ACC_W-1:0] e_c;

    assign x_c = ACC_W'(in_s) <<< FRAC;
    assign e_c = x_c - dc_q;

    // Stage 1: track DC with a one-pole follower and emit the residual
    always_ff @(posedge CLK or negedge RESET_n) begin
      if (!RESET_n) begin
        dc_q <= '0;
        y_q  <= '0;
      end else if (CE) begin
        dc_q <= dc_q + (e_c >>> DC_SHIFT);
        y_q  <= Y_W'(e_c >>> FRAC);
      end
    end
`else
    // Stage 1: pass the sign-extended input through
    always_ff @(posedge CLK or negedge RESET_n) begin
      if (!RESET_n) begin
        y_q <= '0;
      end else if (CE) begin
        y_q <= Y_W'(in_s);
      end
    end
`endif

    assign g_c        = G_W'(y_q) <<< GAIN;
    assign sat_c      = saturate(g_c);
    assign clip_c[ch] = sat_c.clip;
    assign pcm_c[ch]  = pcm_q;

    // Stage 2: gain, clamp and mute into the PCM register
    always_ff @(posedge CLK or negedge RESET_n) begin
      if (!RESET_n) begin
        pcm_q <= '0;
      end else if (s1_valid) begin
        pcm_q <= MUTE ? '0 : sat_c.pcm;
      end
    end
  end

  // Pipeline valids and sticky clip flag; a new saturation beats a clear
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      s1_valid  <= 1'b0;
      PCM_VALID <= 1'b0;
      CLIP      <= 1'b0;
    end else begin
      s1_valid  <= CE;
      PCM_VALID <= s1_valid;
      if (s1_valid && (|clip_c)) begin
        CLIP <= 1'b1;
      end else if (CLIP_CLR) begin
        CLIP <= 1'b0;
      end
    end
  end

  gs_sdm u_sdm_l (
    .CLK     (CLK),
    .RESET_n (RESET_n),
    .PCM     (sample_t'(PCM_L)),
    .DAC     (DAC_L)
  );

  gs_sdm u_sdm_r (
    .CLK     (CLK),
    .RESET_n (RESET_n),
    .PCM     (sample_t'(PCM_R)),
    .DAC     (DAC_R)
  );

endmodule

// File: tb/tb_gs_audio_out.sv
// Directed bench for gs_audio_out; GS_AUDIO_DCBLOCK_EN selects the DC-blocker checks.
`timescale 1ns/1ps
module tb_gs_audio_out;

  logic        CLK = 1'b0;
  logic        RESET_n;
  logic        CE;
  logic [14:0] INL;
  logic [14:0] INR;
  logic [1:0]  GAIN;
  logic        MUTE;
  logic        CLIP_CLR;
  logic [15:0] PCM_L;
  logic [15:0] PCM_R;
  logic        PCM_VALID;
  logic        CLIP;
  logic        DAC_L;
  logic        DAC_R;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 CLK = ~CLK;

  gs_audio_out dut (
    .CLK       (CLK),
    .RESET_n   (RESET_n),
    .CE        (CE),
    .INL       (INL),
    .INR       (INR),
    .GAIN      (GAIN),
    .MUTE      (MUTE),
    .CLIP_CLR  (CLIP_CLR),
    .PCM_L     (PCM_L),
    .PCM_R     (PCM_R),
    .PCM_VALID (PCM_VALID),
    .CLIP      (CLIP),
    .DAC_L     (DAC_L),
    .DAC_R     (DAC_R)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  function automatic int pl();
    return int'($signed(PCM_L));
  endfunction

  function automatic int pr();
    return int'($signed(PCM_R));
  endfunction

  // One CE at edge k; returns at the negedge after edge k+1 (PCM visible)
  task automatic sample(input int l, input int r, input int gain, input bit clr);
    @(negedge CLK);
    INL = 15'(l); INR = 15'(r); GAIN = 2'(gain); CE = 1'b1;
    @(negedge CLK);
    CE = 1'b0; CLIP_CLR = clr;
    @(negedge CLK);
    CLIP_CLR = 1'b0;
  endtask

  task automatic clip_clear();
    @(negedge CLK); CLIP_CLR = 1'b1;
    @(negedge CLK); CLIP_CLR = 1'b0;
  endtask

  // Count DAC ones over 4096 clocks once the SDM sees the settled PCM
  task automatic count_dac(output int cl, output int cr);
    cl = 0; cr = 0;
    repeat (2) @(negedge CLK);
    repeat (4096) begin
      @(negedge CLK);
      cl += int'(DAC_L);
      cr += int'(DAC_R);
    end
  endtask

  initial begin
    int cl, cr, vsum;
    RESET_n = 1'b0; CE = 1'b0; INL = '0; INR = '0; GAIN = '0; MUTE = 1'b0; CLIP_CLR = 1'b0;

    // Reset held with busy inputs
    repeat (10) begin
      @(negedge CLK);
      INL = 15'($urandom); INR = 15'($urandom); CE = 1'($urandom);
      GAIN = 2'($urandom); CLIP_CLR = 1'($urandom);
    end
    check("rst_pcm_l", pl(), 0);
    check("rst_pcm_r", pr(), 0);
    check("rst_valid", int'(PCM_VALID), 0);
    check("rst_clip", int'(CLIP), 0);
    check("rst_dac_l", int'(DAC_L), 0);
    check("rst_dac_r", int'(DAC_R), 0);
    @(negedge CLK);
    CE = 1'b0; CLIP_CLR = 1'b0; GAIN = '0;
    RESET_n = 1'b1;

    // Reset between stage 1 and stage 2 drops the in-flight sample
    @(negedge CLK); INL = 15'(100); INR = 15'(100); CE = 1'b1;
    @(negedge CLK); CE = 1'b0;
    #2 RESET_n = 1'b0;
    #1 RESET_n = 1'b1;
    vsum = 0;
    repeat (3) begin
      @(negedge CLK);
      vsum += int'(PCM_VALID);
    end
    check("midrst_valid", vsum, 0);
    check("midrst_pcm", pl(), 0);

    // Single CE: valid exactly one cycle after the CE edge
    @(negedge CLK); INL = 15'(100); INR = 15'(-100); GAIN = 2'd0; CE = 1'b1;
    @(negedge CLK); CE = 1'b0;
    check("lat_valid_k", int'(PCM_VALID), 0);
    @(negedge CLK);
    check("lat_valid_k1", int'(PCM_VALID), 1);
    check("lat_pcm_l", pl(), 100);
    check("lat_pcm_r", pr(), -100);
    @(negedge CLK);
    check("lat_valid_k2", int'(PCM_VALID), 0);

`ifdef GS_AUDIO_DCBLOCK_EN
    // DC blocker: constant 1000 decays toward zero, CE every 4 clocks
    @(negedge CLK); RESET_n = 1'b0;
    @(negedge CLK); RESET_n = 1'b1;
    for (int i = 0; i < 4096; i++) begin
      sample(1000, 0, 0, 0);
      @(negedge CLK);
      if (i == 0) check("dc_first", pl(), 1000);
      if (i == 255) check("dc_256_near_368", int'(pl() >= 366 && pl() <= 370), 1);
    end
    check("dc_4096_near_0", int'(pl() >= -1 && pl() <= 1), 1);
`else
    // Pass-through gain
    sample(1000, -1000, 2, 0);
    check("gain2_l", pl(), 4000);
    check("gain2_r", pr(), -4000);
    sample(1000, -1000, 0, 0);
    check("gain0_l", pl(), 1000);
    check("gain0_r", pr(), -1000);
    @(negedge CLK); GAIN = 2'd3;
    repeat (2) @(negedge CLK);
    check("gain_not_retro", pl(), 1000);

    // Saturation and sticky clip
    sample(4095, 0, 3, 0);
    check("edge_no_sat_l", pl(), 32760);
    check("edge_no_clip", int'(CLIP), 0);
    sample(16000, 0, 3, 0);
    check("sat_hi_l", pl(), 32767);
    check("sat_hi_clip", int'(CLIP), 1);
    clip_clear();
    check("clr_alone", int'(CLIP), 0);
    sample(-16384, -4096, 3, 0);
    check("sat_lo_l", pl(), -32768);
    check("min_exact_r", pr(), -32768);
    check("sat_lo_clip", int'(CLIP), 1);
    sample(4096, 0, 3, 1);
    check("sat_4096_l", pl(), 32767);
    check("set_beats_clr", int'(CLIP), 1);
    clip_clear();
    check("clr_again", int'(CLIP), 0);
    sample(0, -4096, 3, 0);
    check("neg_full_r", pr(), -32768);
    check("neg_full_noclip", int'(CLIP), 0);

    // Sigma-delta density over 4096 clocks
    sample(0, 0, 0, 0);
    count_dac(cl, cr);
    check("dens_zero_l", cl, 2048);
    check("dens_zero_r", cr, 2048);
    sample(4096, -4096, 2, 0);
    check("dens_pcm_l", pl(), 16384);
    count_dac(cl, cr);
    check("dens_half_l", cl, 3072);
    check("dens_nhalf_r", cr, 1024);
    sample(-16384, 16000, 3, 0);
    count_dac(cl, cr);
    check("dens_min_l", cl, 0);
    check("dens_max_r", int'(cr >= 4095 && cr <= 4096), 1);

    // Mute still reports saturation
    clip_clear();
    check("pre_mute_clip", int'(CLIP), 0);
    @(negedge CLK); MUTE = 1'b1;
    sample(16000, 0, 3, 0);
    check("mute_pcm_l", pl(), 0);
    check("mute_clip", int'(CLIP), 1);
    count_dac(cl, cr);
    check("mute_dens_l", cl, 2048);
    @(negedge CLK); MUTE = 1'b0;
    check("unmute_hold", pl(), 0);
    sample(16000, 0, 3, 0);
    check("unmute_pcm_l", pl(), 32767);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/gs_audio_out.md
Name: gs_audio_out

Overview:
Downstream output stage for the General Sound card. It consumes the card's signed 15-bit left/right mix on the card's sample strobe. It applies per-channel DC removal, programmable gain with saturation and mute, and produces registered 16-bit PCM plus a first-order sigma-delta 1-bit stream per channel for the board's RC DAC pins.

Parameters:
IN_W, 15, input sample width (signed)
OUT_W, 16, PCM output width (signed)
DC_SHIFT, 8, DC-blocker pole shift: dc tracks input with step error/2^DC_SHIFT
FRAC, 8, fractional bits held in DC accumulator

Ports:
CLK  in  1  system clock, single clock domain
RESET_n  in  1  asynchronous active-low reset
CE  in  1  sample strobe, same strobe that updates the card's OUTL/OUTR
INL  in  15  signed left sample from the card
INR  in  15  signed right sample from the card
GAIN  in  2  left shift 0..3 applied after DC removal
MUTE  in  1  forces PCM to 0
CLIP_CLR  in  1  clears sticky CLIP
PCM_L  out  16  signed registered left PCM
PCM_R  out  16  signed registered right PCM
PCM_VALID  out  1  one-cycle pulse when PCM updates
CLIP  out  1  sticky saturation flag
DAC_L  out  1  sigma-delta left bitstream
DAC_R  out  1  sigma-delta right bitstream

Behaviour:
- Reset (async assert, synchronous release edge irrelevant): dc_l/dc_r, stage-1 y regs, PCM_L/R, PCM_VALID, CLIP, SDM accumulators, DAC_L/R all 0.
- Stage 1, on CLK edge with CE=1, per channel:
  - x = sign-extend IN to 24 bits, shifted left by FRAC.
  - e = x - dc.
  - dc <= dc + (e >>> DC_SHIFT) (arithmetic).
  - y <= e >>> FRAC, 17-bit signed; range fits, no wrap.
  - s1_valid <= 1; s1_valid <= 0 on edges with CE=0.
- Stage 2, on the edge after any stage-1 update (s1_valid=1):
  - g = y <<< GAIN (20-bit signed).
  - Saturate g to [-32768, 32767].
  - PCM <= MUTE ? 0 : sat(g).
  - PCM_VALID <= 1 for exactly that cycle.
- Latency: inputs sampled at CE edge k; PCM valid after edge k+1.
- CE high every cycle: full-throughput pipeline, PCM_VALID continuously high.
- GAIN and MUTE are sampled at the stage-2 edge. Changes apply to the next PCM only and never retroactively.
- CLIP:
  - Set when either channel saturates at a stage-2 edge, including while MUTE is high (saturation is evaluated before mute).
  - Cleared by CLIP_CLR=1.
  - Simultaneous set and clear: set wins.
- Sigma-delta, every CLK edge regardless of CE:
  - u = PCM ^ 16'h8000 (offset binary).
  - {c, acc[15:0]} <= acc + u.
  - DAC <= c, registered.
  - Ones density = u/65536, so PCM=0 gives 50% and -32768 gives 0%.
- Reset mid-sample discards any in-flight stage-1 data; no PCM_VALID follows release until a new CE.
- Input values outside 15-bit range cannot occur (port width). The -16384 input is legal.

Optional Feature:
GS_AUDIO_DCBLOCK_EN.
- Defined: DC blocker as above.
- Undefined: y <= sign-extended IN directly; dc registers and DC_SHIFT/FRAC logic not synthesised. Latency, stage-2 and SDM are unchanged.

Decomposition:
- Package gs_audio_pkg holds:
  - IN_W, OUT_W, FRAC defaults.
  - The signed sample typedef (16-bit).
  - A saturate-to-OUT_W function shared by both channels.
- Sub-module gs_sdm: one-channel first-order sigma-delta (CLK, RESET_n, 16-bit PCM in, 1-bit out), instantiated twice.
- Channel filter/gain stays inline (generate over 2 channels).

Test Plan:
1. Hold RESET_n=0 with random inputs and CE toggling -> PCM_L/R=0, PCM_VALID=0, CLIP=0, DAC_L/R=0. Release, then single CE -> PCM_VALID pulses exactly one cycle after the CE edge.
2. DCBLOCK undefined, INL=1000, GAIN=2, one CE -> PCM_L=4000 after edge k+1. INR=-1000, GAIN=0 -> PCM_R=-1000.
3. DCBLOCK defined, INL constant 1000, GAIN=0, CE every 4 clocks:
   - First PCM_L=1000.
   - After 256 samples, PCM_L=368±2.
   - After 4096 samples, PCM_L within ±1 of 0.
4. INL=16000, GAIN=3 -> PCM_L=32767, CLIP=1. INL=-16384, GAIN=3 -> PCM_L=-32768. CLIP_CLR asserted on the same edge as a new saturation -> CLIP stays 1. CLIP_CLR alone -> CLIP=0.
5. Sigma-delta density, counting DAC_L ones over 65536 clocks:
   - PCM_L=0 -> 32768.
   - PCM_L=16384 -> 49152.
   - PCM_L=-32768 -> 0.
   - PCM_L=32767 -> 65535.
6. MUTE=1 with INL=16000, GAIN=3 -> PCM_L=0, CLIP=1, DAC_L density 50%. MUTE deasserted -> next CE restores 32767.
